// File: rtl/oifs_pkg.sv
// rtl/oifs_pkg.sv - shared types and constants for the OIFS transmitter
package oifs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } oifs_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic IDLE_BIT  = 1'b1;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // start bit + payload + channel bit
    function automatic int frame_bits(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/oifs_sync_fifo.sv
// rtl/oifs_sync_fifo.sv - single-clock word FIFO with full/empty/level
module oifs_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/oifs_tx_fifo_framer.sv
// rtl/oifs_tx_fifo_framer.sv - buffered OIFS serial transmitter with FSCLK generator
// Optional build macro OIFS_TX_LEVEL_EN adds o_level and o_overflow.
module oifs_tx_fifo_framer
    import oifs_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int GAP_BITS   = 1
) (
    input  logic              i_clk,
    input  logic              i_srst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_channel,
    output logic              o_ready,
    input  logic              i_fscts,
    output logic              o_fsclk,
    output logic              o_fsdi,
    output logic              o_busy
`ifdef OIFS_TX_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
    output logic              o_overflow
`endif
);
    localparam int FRAME_BITS = frame_bits(DATA_W);
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int GAP_W      = $clog2(GAP_BITS + 1);
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    oifs_state_t       state;
    logic [DIV_W-1:0]  div_cnt;
    logic              div_wrap;
    logic              fall_tick;
    logic              cts_meta;
    logic              cts_sync;
    logic              ready_en;
    logic [DATA_W:0]   shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              gap_last;
    logic              start_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_rd_data;
    logic [LVL_W-1:0]  fifo_level;

    assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_tick = div_wrap && o_fsclk;

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            div_cnt <= '0;
            o_fsclk <= 1'b1;
        end else if (div_wrap) begin
            div_cnt <= '0;
            o_fsclk <= ~o_fsclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            cts_meta <= 1'b0;
            cts_sync <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            cts_meta <= i_fscts;
            cts_sync <= cts_meta;
            ready_en <= 1'b1;
        end
    end

    assign o_ready = ready_en && !fifo_full;

    oifs_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .resetn  (i_srst_n),
        .wr_en   (i_valid && o_ready),
        .wr_data ({i_channel, i_data}),
        .rd_en   (start_ok),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The last gap period doubles as the IDLE check so back-to-back frames carry no extra bubble.
    assign gap_last = (gap_cnt == GAP_W'(GAP_BITS - 1));
    assign start_ok = fall_tick && cts_sync && !fifo_empty &&
                      ((state == IDLE) || ((state == GAP) && gap_last));

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            state   <= IDLE;
            o_fsdi  <= IDLE_BIT;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (start_ok) begin
            o_fsdi  <= START_BIT;
            shreg   <= fifo_rd_data;
            bit_cnt <= '0;
            state   <= SHIFT;
        end else if (fall_tick) begin
            case (state)
                SHIFT: begin
                    if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                        o_fsdi  <= IDLE_BIT;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        o_fsdi  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_last) state <= IDLE;
                    else          gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state != IDLE) || (fifo_level != '0);

`ifdef OIFS_TX_LEVEL_EN
    assign o_level = fifo_level;

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            o_overflow <= 1'b0;
        end else if (i_valid && fifo_full) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_oifs_tx_fifo_framer.sv
// tb/tb_oifs_tx_fifo_framer.sv - randomized self-checking bench for oifs_tx_fifo_framer
module tb_oifs_tx_fifo_framer;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int CLK_DIV    = 4;
    localparam int GAP_BITS   = 1;
    localparam int FRAME_BITS = DATA_W + 2;
    localparam int PERIOD     = 2 * CLK_DIV;

    logic              i_clk = 1'b0;
    logic              i_srst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_channel = 1'b0;
    logic              i_fscts = 1'b0;
    logic              o_ready;
    logic              o_fsclk;
    logic              o_fsdi;
    logic              o_busy;
`ifdef OIFS_TX_LEVEL_EN
    logic [$clog2(FIFO_DEPTH+1)-1:0] o_level;
    logic              o_overflow;
`endif

    oifs_tx_fifo_framer #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS)
    ) dut (
        .i_clk(i_clk), .i_srst_n(i_srst_n), .i_valid(i_valid), .i_data(i_data),
        .i_channel(i_channel), .o_ready(o_ready), .i_fscts(i_fscts),
        .o_fsclk(o_fsclk), .o_fsdi(o_fsdi), .o_busy(o_busy)
`ifdef OIFS_TX_LEVEL_EN
        , .o_level(o_level), .o_overflow(o_overflow)
`endif
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int frames = 0;
    int mon_bits = -1;
    int gap_left = 0;
    int last_start = -1;
    int start_cyc[$];
    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] mon_word = '0;
    logic prev_clk = 1'b1;
    logic prev_di = 1'b1;
    logic [2:0] cts_h = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Line-level reference: every accepted word must appear as start, LSB-first data,
    // channel, then GAP_BITS high periods, sampled on FSCLK rising edges.
    always @(posedge i_clk) begin : mon
        logic in_rst;
        logic push;
        logic [DATA_W:0] w;
        in_rst = !i_srst_n;
        push   = i_valid && o_ready && i_srst_n;
        w      = {i_channel, i_data};
        cts_h  = {cts_h[1:0], i_fscts};
        cyc++;
        if (push) exp_q.push_back(w);
        #1;
        if (in_rst) begin
            mon_bits = -1;
            gap_left = 0;
            exp_q.delete();
        end else begin
            if (o_fsdi !== prev_di) begin
                check("fsdi_changes_on_fall", {prev_clk, o_fsclk}, 32'b10);
                if (prev_di === 1'b1 && o_fsdi === 1'b0 && mon_bits < 0) begin
                    check("start_needs_cts", cts_h[2], 1);
                    last_start = cyc;
                    start_cyc.push_back(cyc);
                end
            end
            if (prev_clk === 1'b0 && o_fsclk === 1'b1) begin
                if (gap_left > 0) begin
                    check("gap_high", o_fsdi, 1);
                    gap_left--;
                end else if (mon_bits < 0) begin
                    if (o_fsdi === 1'b0) mon_bits = 0;
                end else begin
                    mon_word[mon_bits] = o_fsdi;
                    mon_bits++;
                    if (mon_bits == DATA_W + 1) begin
                        frames++;
                        if (exp_q.size() > 0) check("frame_word", mon_word, exp_q.pop_front());
                        else check("frame_unexpected", 1, 0);
                        mon_bits = -1;
                        gap_left = GAP_BITS;
                    end
                end
            end
        end
        prev_clk = o_fsclk;
        prev_di  = o_fsdi;
    end

    task automatic send(input logic [DATA_W:0] w);
        int n = 0;
        while (o_ready !== 1'b1 && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        check("send_ready", o_ready, 1);
        i_valid = 1'b1;
        {i_channel, i_data} = w;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && mon_bits < 0 && gap_left == 0 && o_busy === 1'b0) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic wait_start(input string tag, input int s0, input int budget);
        int n = 0;
        while (start_cyc.size() <= s0 && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, start_cyc.size() > s0, 1);
    endtask

    task automatic wait_bits(input string tag, input int target, input int budget);
        int n = 0;
        while (mon_bits != target && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, mon_bits, target);
    endtask

    initial begin
        int s0, last, fb, c0, wcyc, n;
        logic pc;
        logic [10:0] got;

        repeat (3) @(negedge i_clk);
        check("rst_fsdi", o_fsdi, 1);
        check("rst_fsclk", o_fsclk, 1);
        check("rst_ready", o_ready, 0);
        check("rst_busy", o_busy, 0);
        i_srst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst", o_ready, 1);
        check("busy_after_rst", o_busy, 0);

        // idle line, CTS low
        pc = o_fsclk;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_fsclk !== pc) begin
                if (last >= 0) check("fsclk_half_period", i - last, CLK_DIV);
                last = i;
            end
            pc = o_fsclk;
        end
        check("idle_fsdi", o_fsdi, 1);
        check("idle_frames", frames, 0);

        // single 0xA5 on channel B with latency and bit-order check
        i_fscts = 1'b1;
        repeat (4) @(negedge i_clk);
        s0 = start_cyc.size();
        wcyc = cyc + 1;
        send({1'b1, 8'hA5});
        wait_start("a5_start", s0, 50);
        check("a5_latency_ok", (last_start - wcyc >= 1) && (last_start - wcyc <= 2 + 2 * CLK_DIV), 1);
        got = '0;
        n = 0;
        pc = o_fsclk;
        for (int i = 0; i < 200 && n < 11; i++) begin
            @(negedge i_clk);
            if (pc === 1'b0 && o_fsclk === 1'b1) begin
                got = {got[9:0], o_fsdi};
                n++;
            end
            pc = o_fsclk;
        end
        check("a5_bits", got, 11'b01010010111);
        drain("a5_drain", 400);

        // fill the FIFO with CTS low, then release a back-to-back burst
        i_fscts = 1'b0;
        repeat (4) @(negedge i_clk);
        for (int i = 0; i < FIFO_DEPTH; i++) send((DATA_W+1)'($urandom));
        check("full_ready", o_ready, 0);
        check("full_busy", o_busy, 1);
        s0 = start_cyc.size();
        i_fscts = 1'b1;
        wait_start("burst_start", s0, 40);
        @(negedge i_clk);
        check("ready_after_pop", o_ready, 1);
        drain("burst_drain", FIFO_DEPTH * 100 + 200);
        for (int i = s0 + 1; i < s0 + FIFO_DEPTH; i++)
            check("frame_period", start_cyc[i] - start_cyc[i-1], (FRAME_BITS + GAP_BITS) * PERIOD);

        // CTS drops during the 5th data bit
        send((DATA_W+1)'($urandom));
        send((DATA_W+1)'($urandom));
        wait_bits("cts_drop_point", 4, 300);
        i_fscts = 1'b0;
        fb = frames;
        s0 = start_cyc.size();
        repeat (200) @(negedge i_clk);
        check("cts_frame_completed", frames, fb + 1);
        check("cts_held_word", exp_q.size(), 1);
        check("cts_no_new_start", start_cyc.size(), s0);
        c0 = cyc;
        i_fscts = 1'b1;
        wait_start("cts_resume", s0, 40);
        check("cts_resume_latency_ok", (last_start - c0 >= 3) && (last_start - c0 <= 3 + PERIOD), 1);
        drain("cts_drain", 400);

        // reset during data bit 3
        send((DATA_W+1)'($urandom));
        wait_bits("rst_point", 3, 300);
        i_srst_n = 1'b0;
        @(negedge i_clk);
        check("midrst_fsdi", o_fsdi, 1);
        @(negedge i_clk);
        i_srst_n = 1'b1;
        @(negedge i_clk);
        check("midrst_busy", o_busy, 0);
        check("midrst_ready", o_ready, 1);
        check("midrst_fsdi_after", o_fsdi, 1);
        fb = frames;
        send((DATA_W+1)'($urandom));
        drain("post_rst_drain", 400);
        check("post_rst_frame", frames, fb + 1);

        // random traffic with CTS wandering
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            if ($urandom_range(0, 99) < 3) i_fscts = ~i_fscts;
            if (o_ready && $urandom_range(0, 3) == 0) begin
                i_valid = 1'b1;
                {i_channel, i_data} = (DATA_W+1)'($urandom);
            end else begin
                i_valid = 1'b0;
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_fscts = 1'b1;
        drain("random_drain", FIFO_DEPTH * 100 + 400);

`ifdef OIFS_TX_LEVEL_EN
        i_fscts = 1'b0;
        repeat (4) @(negedge i_clk);
        check("level_empty", o_level, 0);
        check("overflow_clear", o_overflow, 0);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            i_valid = 1'b1;
            {i_channel, i_data} = (DATA_W+1)'($urandom);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        check("level_full", o_level, FIFO_DEPTH);
        check("overflow_set", o_overflow, 1);
        repeat (20) @(negedge i_clk);
        check("level_hold", o_level, FIFO_DEPTH);
        check("overflow_sticky", o_overflow, 1);
        i_srst_n = 1'b0;
        @(negedge i_clk);
        i_srst_n = 1'b1;
        @(negedge i_clk);
        check("level_rst", o_level, 0);
        check("overflow_rst", o_overflow, 0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
